// File: rtl/fir_coef_ctrl.sv
// Coefficient-update controller between the I2C slave and the FIR datapath.
// Decodes byte events, supplies ACK/NACK, stages 2*NTAPS bytes, and commits on sample_tick_in.
// Optional macro FIR_COEF_CHKSUM_EN adds a trailing checksum byte (8-bit sum of frame must be 0).
module fir_coef_ctrl #(
  parameter int         NTAPS    = 4,
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic                 valid_in,
  input  logic [NTAPS*16-1:0]  data_in,
  output logic                 ack_out,
  input  logic                 sample_tick_in,
  output logic [NTAPS*16-1:0]  coef_out,
  output logic                 coef_update_out,
  output logic                 coef_valid_out,
  output logic                 busy_out,
  output logic                 err_out
);

  localparam int W      = NTAPS * 16;
  localparam int NBYTES = 2 * NTAPS;
  localparam int CW     = $clog2(NBYTES + 2);
`ifdef FIR_COEF_CHKSUM_EN
  localparam int NFRAME = NBYTES + 1;
`else
  localparam int NFRAME = NBYTES;
`endif
  localparam logic [CW-1:0] CNT_NB  = CW'(NBYTES);
  localparam logic [CW-1:0] CNT_LIM = CW'(NFRAME);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, SKIP, PEND} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   stage_q, stage_d;
  logic [W-1:0]   coef_q, coef_d;
  logic           upd_q, upd_d;
  logic           cvld_q, cvld_d;
  logic           err_q, err_d;
`ifdef FIR_COEF_CHKSUM_EN
  logic [7:0]     sum_q, sum_d;
`endif

  logic [7:0] byte_w;
  logic       addr_ok;
  logic       frame_ok;
  logic       unused_data;

  // Only the low byte of the slave shift register carries the received byte.
  assign byte_w      = data_in[7:0];
  assign unused_data = ^data_in[W-1:8];
  assign addr_ok     = (byte_w[7:1] == DEV_ADDR) && !byte_w[0];

`ifdef FIR_COEF_CHKSUM_EN
  assign frame_ok = (cnt_q == CNT_LIM) && (sum_q == 8'h00);
`else
  assign frame_ok = (cnt_q == CNT_NB);
`endif

  // ACK/NACK decision; combinational so it follows data_in during the ACK bit.
  always_comb begin
    ack_out = 1'b1;
    case (state_q)
      ADDR:    ack_out = !addr_ok;
      DATA:    ack_out = (cnt_q >= CNT_LIM);
      default: ack_out = 1'b1;
    endcase
  end

  // Frame decode: next state, byte staging and the sample-aligned commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    coef_d  = coef_q;
    upd_d   = 1'b0;
    cvld_d  = cvld_q;
    err_d   = 1'b0;
`ifdef FIR_COEF_CHKSUM_EN
    sum_d   = sum_q;
`endif
    if (start_in && state_q != PEND) begin
      // (Repeated) START throws away whatever was staged and restarts the frame.
      state_d = ADDR;
      cnt_d   = '0;
      stage_d = '0;
`ifdef FIR_COEF_CHKSUM_EN
      sum_d   = 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ADDR: begin
          if (stop_in)       state_d = IDLE;
          else if (valid_in) state_d = addr_ok ? DATA : SKIP;
        end
        DATA: begin
          if (stop_in) begin
            if (frame_ok) begin
              state_d = PEND;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else if (valid_in && cnt_q < CNT_LIM) begin
            // The checksum byte (if any) is summed but never staged.
            if (cnt_q < CNT_NB) stage_d = {stage_q[W-9:0], byte_w};
            cnt_d = cnt_q + 1'b1;
`ifdef FIR_COEF_CHKSUM_EN
            sum_d = sum_q + byte_w;
`endif
          end
        end
        SKIP: begin
          if (stop_in) state_d = IDLE;
        end
        PEND: begin
          // Commit lands exactly on a sample boundary; START/STOP are ignored meanwhile.
          if (sample_tick_in) begin
            state_d = IDLE;
            coef_d  = stage_q;
            upd_d   = 1'b1;
            cvld_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      coef_q  <= '0;
      upd_q   <= 1'b0;
      cvld_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FIR_COEF_CHKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      coef_q  <= coef_d;
      upd_q   <= upd_d;
      cvld_q  <= cvld_d;
      err_q   <= err_d;
`ifdef FIR_COEF_CHKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign coef_out        = coef_q;
  assign coef_update_out = upd_q;
  assign coef_valid_out  = cvld_q;
  assign err_out         = err_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl (NTAPS=4, DEV_ADDR=7'h42).
// Inputs change 1 time unit after posedge; outputs are sampled after the edge or on negedge.
// Builds with or without FIR_COEF_CHKSUM_EN; frames get a checksum byte when it is defined.
module tb_fir_coef_ctrl;
  localparam int NTAPS = 4;
  localparam int W     = NTAPS * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in, stop_in, valid_in, sample_tick_in;
  logic [W-1:0] data_in;
  logic         ack_out;
  logic [W-1:0] coef_out;
  logic         coef_update_out, coef_valid_out, busy_out, err_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] fb [0:7];

  always #5 clk = ~clk;

  fir_coef_ctrl #(.NTAPS(NTAPS), .DEV_ADDR(7'h42)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .stop_in        (stop_in),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .ack_out        (ack_out),
    .sample_tick_in (sample_tick_in),
    .coef_out       (coef_out),
    .coef_update_out(coef_update_out),
    .coef_valid_out (coef_valid_out),
    .busy_out       (busy_out),
    .err_out        (err_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    start_in = 1'b1; @(posedge clk); #1; start_in = 1'b0;
  endtask

  task automatic do_stop();
    stop_in = 1'b1; @(posedge clk); #1; stop_in = 1'b0;
  endtask

  task automatic do_tick();
    sample_tick_in = 1'b1; @(posedge clk); #1; sample_tick_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    data_in  = {{(W-8){1'b0}}, b};
    valid_in = 1'b1;
    @(negedge clk);
    check(tag, 64'(ack_out), 64'(exp_ack));
    @(posedge clk); #1;
    valid_in = 1'b0;
    idle(1);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) fb[i] = base + 8'(i);
  endtask

  // Sends fb[0..n-1]; a full frame also gets its checksum byte in the checksum build.
  task automatic send_body(input int n, input string tag);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], 1'b0, tag);
      s = s + fb[i];
    end
`ifdef FIR_COEF_CHKSUM_EN
    if (n == 8) send_byte(8'h00 - s, 1'b0, {tag, "_chk"});
`endif
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; valid_in = 1'b0;
    sample_tick_in = 1'b0; data_in = '0;
    idle(2);
    check("rst_coef", coef_out, 64'h0);
    check("rst_upd",  64'(coef_update_out), 64'h0);
    check("rst_cvld", 64'(coef_valid_out), 64'h0);
    check("rst_busy", 64'(busy_out), 64'h0);
    check("rst_err",  64'(err_out), 64'h0);
    rst = 1'b0;
    idle(1);
    check("idle_ack", 64'(ack_out), 64'h1);

    // 1: good frame, commit 5 cycles later on a tick
    do_start();
    send_byte(8'h84, 1'b0, "t1_addr");
    fill(8'h01);
    send_body(8, "t1_data");
    do_stop();
    check("t1_pend_busy", 64'(busy_out), 64'h1);
    check("t1_pend_ack",  64'(ack_out), 64'h1);
    idle(4);
    check("t1_hold", coef_out, 64'h0);
    do_tick();
    check("t1_coef", coef_out, 64'h0102030405060708);
    check("t1_upd",  64'(coef_update_out), 64'h1);
    idle(1);
    check("t1_upd_end", 64'(coef_update_out), 64'h0);
    check("t1_cvld",    64'(coef_valid_out), 64'h1);
    check("t1_busy",    64'(busy_out), 64'h0);

    // 2: wrong address -> NACK, skip, no error
    do_start();
    send_byte(8'h86, 1'b1, "t2_addr");
    fill(8'h21);
    for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b1, "t2_skip");
    do_stop();
    check("t2_err",  64'(err_out), 64'h0);
    check("t2_busy", 64'(busy_out), 64'h0);
    check("t2_coef", coef_out, 64'h0102030405060708);

    // 3: short frame -> error pulse, coef held
    do_start();
    send_byte(8'h84, 1'b0, "t3_addr");
    fill(8'h31);
    send_body(5, "t3_data");
    do_stop();
    check("t3_err",  64'(err_out), 64'h1);
    check("t3_busy", 64'(busy_out), 64'h0);
    idle(1);
    check("t3_err_end", 64'(err_out), 64'h0);
    check("t3_coef",    coef_out, 64'h0102030405060708);

    // 4: repeated start discards the first partial frame
    do_start();
    send_byte(8'h84, 1'b0, "t4_addr1");
    fill(8'h51);
    send_body(3, "t4_part");
    do_start();
    send_byte(8'h84, 1'b0, "t4_addr2");
    fill(8'hAA);
    send_body(8, "t4_data");
    do_stop();
    do_tick();
    check("t4_coef", coef_out, 64'hAAABACADAEAFB0B1);

    // 5: overflow byte NACKed; stop coincident with tick defers commit
    do_start();
    send_byte(8'h84, 1'b0, "t5_addr");
    fill(8'h11);
    send_body(8, "t5_data");
    send_byte(8'h99, 1'b1, "t5_ovf");
    stop_in = 1'b1; sample_tick_in = 1'b1;
    @(posedge clk); #1;
    stop_in = 1'b0; sample_tick_in = 1'b0;
    check("t5_busy", 64'(busy_out), 64'h1);
    check("t5_upd0", 64'(coef_update_out), 64'h0);
    check("t5_hold", coef_out, 64'hAAABACADAEAFB0B1);
    idle(9);
    do_tick();
    check("t5_coef", coef_out, 64'h1112131415161718);
    check("t5_upd",  64'(coef_update_out), 64'h1);

`ifdef FIR_COEF_CHKSUM_EN
    // 6: checksum accept / reject
    do_start();
    send_byte(8'h84, 1'b0, "t6_addr");
    fill(8'h01);
    for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b0, "t6_data");
    send_byte(8'hDC, 1'b0, "t6_chk");
    do_stop();
    do_tick();
    check("t6_coef", coef_out, 64'h0102030405060708);
    do_start();
    send_byte(8'h84, 1'b0, "t6b_addr");
    fill(8'h01);
    for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b0, "t6b_data");
    send_byte(8'hDD, 1'b0, "t6b_chk");
    do_stop();
    check("t6b_err", 64'(err_out), 64'h1);
    do_tick();
    check("t6b_coef", coef_out, 64'h0102030405060708);
`endif

    // Reset mid-frame clears everything, including committed coefficients
    do_start();
    send_byte(8'h84, 1'b0, "mr_addr");
    fill(8'h61);
    send_body(3, "mr_data");
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_coef", coef_out, 64'h0);
    check("mr_cvld", 64'(coef_valid_out), 64'h0);
    check("mr_busy", 64'(busy_out), 64'h0);
    check("mr_upd",  64'(coef_update_out), 64'h0);
    check("mr_err",  64'(err_out), 64'h0);
    rst = 1'b0;
    idle(1);
    check("mr_ack", 64'(ack_out), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
